// File: rtl/decode.sv
// Decode stage: turns fetch words into execute micro-ops and resolves jumps/branches.
// Latency: 1 cycle from fe handshake to exe_valid_o or fe_valid_o.
// Backpressure: fe_ready_o = !exe_valid_o; a pending micro-op is held stable until exe_ready_i.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   fe_valid_i/fe_ready_o, fe_addr_i, fe_inst_i   instruction word from fetch
//   fe_valid_o, fe_pc_o  one-cycle PC load request back to fetch
//   reg_src_addr_o/reg_src_data_i, reg_dst_addr_o/reg_dst_data_i   register file read ports
//   exe_valid_o/exe_ready_i, exe_opcode_o, exe_src_val_o, exe_dst_val_o, exe_dst_reg_o, exe_addr_o
module decode #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fe_valid_i,
  output logic        fe_ready_o,
  input  logic [15:0] fe_addr_i,
  input  logic [15:0] fe_inst_i,
  output logic        fe_valid_o,
  output logic [15:0] fe_pc_o,
  output logic [3:0]  reg_src_addr_o,
  input  logic [15:0] reg_src_data_i,
  output logic [3:0]  reg_dst_addr_o,
  input  logic [15:0] reg_dst_data_i,
  output logic        exe_valid_o,
  input  logic        exe_ready_i,
  output logic [3:0]  exe_opcode_o,
  output logic [15:0] exe_src_val_o,
  output logic [15:0] exe_dst_val_o,
  output logic [3:0]  exe_dst_reg_o,
  output logic [15:0] exe_addr_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IMM_MOV = 2'd1,
    ST_IMM_JMP = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [15:0] src_val;
    logic [15:0] dst_val;
    logic [3:0]  dst_reg;
    logic [15:0] addr;
  } uop_t;

  localparam logic [3:0] OP_MOVI = 4'hE;
  localparam logic [3:0] OP_JUMP = 4'hF;
  localparam logic [3:0] MODE_JMPR = 4'd0;
  localparam logic [3:0] MODE_JMPI = 4'd1;
  localparam logic [3:0] MODE_BRA  = 4'd2;

  state_t      state_q, state_d;
  uop_t        uop_q, uop_d;
  logic        exe_vld_q, exe_vld_d;
  logic        fe_vld_q, fe_vld_d;
  logic [15:0] fe_pc_q, fe_pc_d;
  // First-word context of a MOVI, needed when its immediate arrives.
  logic [3:0]  mov_dst_q, mov_dst_d;
  logic [15:0] mov_addr_q, mov_addr_d;
  logic [15:0] mov_dval_q, mov_dval_d;

  logic [3:0] opc;
  logic [3:0] mode;
  logic       fe_take;

  assign opc            = fe_inst_i[15:12];
  assign mode           = fe_inst_i[3:0];
  assign reg_src_addr_o = fe_inst_i[11:8];
  assign reg_dst_addr_o = fe_inst_i[7:4];
  assign fe_ready_o     = !exe_vld_q;

  // A word handshaken while a PC load is being issued comes from the old
  // instruction stream, so it is accepted but ignored.
  assign fe_take = fe_valid_i && fe_ready_o && !fe_vld_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (fe_take) begin
      case (state_q)
        ST_IDLE: begin
          if (opc == OP_MOVI) begin
            state_d = ST_IMM_MOV;
          end else if (opc == OP_JUMP && mode == MODE_JMPI) begin
            state_d = ST_IMM_JMP;
          end
        end
        ST_IMM_MOV: state_d = ST_IDLE;
        ST_IMM_JMP: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next-value logic
  always_comb begin
    uop_d      = uop_q;
    exe_vld_d  = exe_vld_q && !exe_ready_i;
    fe_vld_d   = 1'b0;
    fe_pc_d    = fe_pc_q;
    mov_dst_d  = mov_dst_q;
    mov_addr_d = mov_addr_q;
    mov_dval_d = mov_dval_q;
    if (fe_take) begin
      case (state_q)
        ST_IDLE: begin
          if (opc < OP_MOVI) begin
            uop_d.opcode  = opc;
            uop_d.src_val = reg_src_data_i;
            uop_d.dst_val = reg_dst_data_i;
            uop_d.dst_reg = fe_inst_i[7:4];
            uop_d.addr    = fe_addr_i;
            exe_vld_d     = 1'b1;
          end else if (opc == OP_MOVI) begin
            mov_dst_d  = fe_inst_i[7:4];
            mov_addr_d = fe_addr_i;
            mov_dval_d = reg_dst_data_i;
          end else if (mode == MODE_JMPR) begin
            fe_vld_d = 1'b1;
            fe_pc_d  = reg_src_data_i;
          end else if (mode == MODE_BRA) begin
            // Wraps naturally at 16 bits.
            fe_vld_d = 1'b1;
            fe_pc_d  = fe_addr_i + 16'd1 + reg_src_data_i;
          end
          // JMPI waits for its target word; other jump modes are NOPs.
        end
        ST_IMM_MOV: begin
          uop_d.opcode  = OP_MOVI;
          uop_d.src_val = fe_inst_i;
          uop_d.dst_val = mov_dval_q;
          uop_d.dst_reg = mov_dst_q;
          uop_d.addr    = mov_addr_q;
          exe_vld_d     = 1'b1;
        end
        ST_IMM_JMP: begin
          fe_vld_d = 1'b1;
          fe_pc_d  = fe_inst_i;
        end
        default: begin
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      uop_q      <= '0;
      exe_vld_q  <= 1'b0;
      fe_vld_q   <= 1'b1;
      fe_pc_q    <= RESET_PC;
      mov_dst_q  <= '0;
      mov_addr_q <= '0;
      mov_dval_q <= '0;
    end else begin
      uop_q      <= uop_d;
      exe_vld_q  <= exe_vld_d;
      fe_vld_q   <= fe_vld_d;
      fe_pc_q    <= fe_pc_d;
      mov_dst_q  <= mov_dst_d;
      mov_addr_q <= mov_addr_d;
      mov_dval_q <= mov_dval_d;
    end
  end

  assign fe_valid_o    = fe_vld_q;
  assign fe_pc_o       = fe_pc_q;
  assign exe_valid_o   = exe_vld_q;
  assign exe_opcode_o  = uop_q.opcode;
  assign exe_src_val_o = uop_q.src_val;
  assign exe_dst_val_o = uop_q.dst_val;
  assign exe_dst_reg_o = uop_q.dst_reg;
  assign exe_addr_o    = uop_q.addr;

endmodule

// File: doc/decode.md
# decode

Second pipeline stage of the 16-bit CPU, directly downstream of `fetch`. Accepts one instruction word at a time from `fetch`, reads source and destination operands from the external register file, and hands a decoded micro-op to `execute`. Resolves jumps and branches locally and sends the new PC back to `fetch`. It also issues the mandatory PC load on the cycle after reset.

## Interface
Parameters:
- `RESET_PC`, 16'h0000: PC sent to `fetch` on the first cycle after reset.

Ports:
- `clk_i`  in  1  Clock. Single clock domain.
- `rst_i`  in  1  Reset. Synchronous, active-high.
- `fe_valid_i`  in  1  Instruction word from `fetch` is valid.
- `fe_ready_o`  out  1  Decode can accept an instruction word.
- `fe_addr_i`  in  16  Address of the instruction word.
- `fe_inst_i`  in  16  Instruction word.
- `fe_valid_o`  out  1  One-cycle request for `fetch` to load a new PC.
- `fe_pc_o`  out  16  New PC for `fetch`.
- `reg_src_addr_o`  out  4  Register file read port A address. Combinational, equal to `fe_inst_i[11:8]`.
- `reg_src_data_i`  in  16  Read port A data. Combinational read.
- `reg_dst_addr_o`  out  4  Register file read port B address. Combinational, equal to `fe_inst_i[7:4]`.
- `reg_dst_data_i`  in  16  Read port B data.
- `exe_valid_o`  out  1  Micro-op to `execute` is valid.
- `exe_ready_i`  in  1  `execute` accepts the micro-op.
- `exe_opcode_o`  out  4  ALU opcode. 4'hE means MOV.
- `exe_src_val_o`  out  16  Source operand value.
- `exe_dst_val_o`  out  16  Destination operand value.
- `exe_dst_reg_o`  out  4  Write-back register.
- `exe_addr_o`  out  16  Address of the instruction, for traps and debug.

## Operation
Instruction format:
- `[15:12]` opcode, `[11:8]` src reg, `[7:4]` dst reg, `[3:0]` mode.

Opcodes:
- Opcodes 0x0–0xD are ALU ops. Issue to execute with `src_val = R[src]`, `dst_val = R[dst]`, `dst_reg = dst`.
- 0xE is MOVI, two words. The next word is an immediate. Issue opcode 0xE with `src_val` = the immediate and `dst_reg` = dst.
- 0xF with mode 0 is JMPR: new PC = R[src].
- 0xF with mode 1 is JMPI, two words: new PC = the next word.
- 0xF with mode 2 is BRA: new PC = `fe_addr_i + 1 + R[src]`, computed mod 2^16 (wrap-around, no overflow flag).
- 0xF with any other mode is treated as a NOP. It is accepted and produces no output.

Handshake:
- `fe_ready_o = !exe_valid_o`, combinational. A new word is accepted only when the output register is empty. This guarantees that the register write-back of the previous op is committed on its `exe` handshake edge, before the next operand read.
- An `exe` transfer occurs on the edge where `exe_valid_o && exe_ready_i`.
- While `exe_valid_o && !exe_ready_i`, all `exe_*` outputs are held stable.
- Operands are sampled on the `fe` handshake edge.

State machine:
- IDLE:
  - ALU op: load the `exe_*` registers and set `exe_valid_o`. Stay in IDLE.
  - MOVI: latch dst and addr, go to IMM_MOV.
  - JMPI: go to IMM_JMP.
  - JMPR or BRA: set `fe_valid_o` and `fe_pc_o` for one cycle.
- IMM_MOV: on the next `fe` handshake, issue the MOV with the immediate, then go to IDLE.
- IMM_JMP: on the next `fe` handshake, pulse `fe_valid_o` with `fe_pc_o` = the word, then go to IDLE.
- On any cycle where `fe_valid_o = 1`, a word accepted from `fetch` in that same cycle is discarded. It is stale.

Reset:
- `fe_valid_o` = 1, `fe_pc_o` = `RESET_PC`, `exe_valid_o` = 0, state = IDLE.
- All other `exe_*` outputs = 0.
- `fe_ready_o` = 1 on the first cycle after reset.
- Reset mid-IMM discards the partial instruction.

## Timing
- Latency is 1 cycle from the `fe` handshake to `exe_valid_o`, or to `fe_valid_o`.
- `fe_valid_o` is never high for two consecutive cycles except when reset is held.
- `fe_ready_o` only deasserts on the cycle after an `fe` handshake. It stays high while `fetch` presents nothing.
- Back-to-back: with `exe_ready_i = 1`, `exe_valid_o` is high for one cycle and `fe_ready_o` returns high the following cycle.

## Test plan
- Reset, then release -> first cycle: `fe_valid_o = 1`, `fe_pc_o = 0x0000`, `fe_ready_o = 1`, `exe_valid_o = 0`.
- ALU 0x3120 at 0x0010 with R1 = 5, R2 = 7, `exe_ready_i` low for 3 cycles -> next cycle `exe_opcode_o = 3`, `src_val = 5`, `dst_val = 7`, `dst_reg = 2`, `addr = 0x0010`, all held stable for 3 cycles. `fe_ready_o = 0` until the transfer.
- MOVI 0xE050 followed by word 0xBEEF -> single issue of opcode 0xE, `src_val = 0xBEEF`, `dst_reg = 5`. No `exe_valid_o` after the first word.
- BRA 0xF302 at 0xFFF0 with R3 = 0x0020 -> `fe_valid_o` pulse with `fe_pc_o = 0x0011` (wrap-around). No `exe_valid_o`.
- JMPI 0xF001 followed by word 0x1234, and a stale word presented in the pulse cycle -> `fe_pc_o = 0x1234`, and the stale word is dropped.
- `rst_i` asserted while in IMM_MOV -> state IDLE and `fe_pc_o = RESET_PC`. The next word is decoded as a fresh instruction.
